// File: rtl/hwag_spi_cmd_ctrl_if.sv
// Signal bundle between the HWAG SPI command controller and its SPI slave / register file.
// master = the controller, slave = the surrounding logic that drives it.
interface hwag_spi_cmd_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  spi_ss;
    logic                  rx_strobe;
    logic [7:0]            rx_byte;
    logic [7:0]            crc_rx;
    logic                  tx_strobe;
    logic [7:0]            tx_byte;
    logic                  reg_wr_en;
    logic                  reg_rd_en;
    logic [7:0]            reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  reg_rd_valid;
    logic                  frame_ok;
    logic [7:0]            crc_err_cnt;
    logic [7:0]            abort_cnt;

    modport master (
        input  spi_ss, rx_strobe, rx_byte, crc_rx, tx_strobe, reg_rdata, reg_rd_valid,
        output tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_ok,
               crc_err_cnt, abort_cnt
    );

    modport slave (
        output spi_ss, rx_strobe, rx_byte, crc_rx, tx_strobe, reg_rdata, reg_rd_valid,
        input  tx_byte, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_ok,
               crc_err_cnt, abort_cnt
    );
endinterface

// File: rtl/hwag_spi_cmd_ctrl.sv
// Assembles 7-byte SPI command frames, checks the CRC, issues register writes/reads
// and serves a status/readback frame on the following SPI transaction.
module hwag_spi_cmd_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RD_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    hwag_spi_cmd_ctrl_if.master bus
);

    localparam int unsigned WIRE_W   = 32;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned TO_W     = 4;
    localparam int unsigned LAST_IDX = 6;
    localparam logic [7:0]  CMD_WR   = 8'h01;
    localparam logic [7:0]  CMD_RD   = 8'h02;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RD_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV,
        ST_EXEC,
        ST_RDWAIT,
        ST_DISCARD
    } state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   rx_idx, rx_idx_nxt;
    logic [5:0][7:0]    rx_buf, rx_buf_nxt;
    logic               crc_ok, crc_ok_nxt;
    logic [IDX_W-1:0]   tx_idx, tx_idx_nxt;
    logic [7:0]         tx_byte, tx_byte_nxt;
    logic               reg_wr_en, reg_wr_en_nxt;
    logic               reg_rd_en, reg_rd_en_nxt;
    logic [7:0]         reg_addr, reg_addr_nxt;
    logic [WIRE_W-1:0]  reg_wdata, reg_wdata_nxt;
    logic               frame_ok, frame_ok_nxt;
    logic [7:0]         crc_err_cnt, crc_err_cnt_nxt;
    logic [7:0]         abort_cnt, abort_cnt_nxt;
    logic [7:0]         status, status_nxt;
    logic [7:0]         last_addr, last_addr_nxt;
    logic [WIRE_W-1:0]  tx_shadow, tx_shadow_nxt;
    logic [WIRE_W-1:0]  pend_shadow, pend_shadow_nxt;
    logic               pend_valid, pend_valid_nxt;
    logic               ovl_seen, ovl_seen_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic               crc_err_inc, abort_inc, crc_match, last_rx;
    logic [7:0]         tx_mux;

    assign crc_match = (bus.rx_byte == bus.crc_rx);
    assign last_rx   = bus.rx_strobe && (rx_idx == IDX_W'(LAST_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rx_idx      <= '0;
            rx_buf      <= '0;
            crc_ok      <= 1'b0;
            tx_idx      <= '0;
            tx_byte     <= 8'h00;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_addr    <= 8'h00;
            reg_wdata   <= '0;
            frame_ok    <= 1'b0;
            crc_err_cnt <= 8'h00;
            abort_cnt   <= 8'h00;
            status      <= 8'h00;
            last_addr   <= 8'h00;
            tx_shadow   <= '0;
            pend_shadow <= '0;
            pend_valid  <= 1'b0;
            ovl_seen    <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            rx_idx      <= rx_idx_nxt;
            rx_buf      <= rx_buf_nxt;
            crc_ok      <= crc_ok_nxt;
            tx_idx      <= tx_idx_nxt;
            tx_byte     <= tx_byte_nxt;
            reg_wr_en   <= reg_wr_en_nxt;
            reg_rd_en   <= reg_rd_en_nxt;
            reg_addr    <= reg_addr_nxt;
            reg_wdata   <= reg_wdata_nxt;
            frame_ok    <= frame_ok_nxt;
            crc_err_cnt <= crc_err_cnt_nxt;
            abort_cnt   <= abort_cnt_nxt;
            status      <= status_nxt;
            last_addr   <= last_addr_nxt;
            tx_shadow   <= tx_shadow_nxt;
            pend_shadow <= pend_shadow_nxt;
            pend_valid  <= pend_valid_nxt;
            ovl_seen    <= ovl_seen_nxt;
            to_cnt      <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        rx_idx_nxt      = rx_idx;
        rx_buf_nxt      = rx_buf;
        crc_ok_nxt      = crc_ok;
        tx_idx_nxt      = tx_idx;
        tx_byte_nxt     = tx_byte;
        reg_wr_en_nxt   = 1'b0;
        reg_rd_en_nxt   = 1'b0;
        reg_addr_nxt    = reg_addr;
        reg_wdata_nxt   = reg_wdata;
        frame_ok_nxt    = 1'b0;
        crc_err_cnt_nxt = crc_err_cnt;
        abort_cnt_nxt   = abort_cnt;
        status_nxt      = status;
        last_addr_nxt   = last_addr;
        tx_shadow_nxt   = tx_shadow;
        pend_shadow_nxt = pend_shadow;
        pend_valid_nxt  = pend_valid;
        ovl_seen_nxt    = ovl_seen;
        to_cnt_nxt      = to_cnt;
        crc_err_inc     = 1'b0;
        abort_inc       = 1'b0;
        tx_mux          = 8'h00;

        case (state)
            ST_IDLE: begin
                rx_idx_nxt   = '0;
                ovl_seen_nxt = 1'b0;
                // Readback data only reaches the tx shadow between transactions.
                if (bus.spi_ss && pend_valid) begin
                    tx_shadow_nxt  = pend_shadow;
                    pend_valid_nxt = 1'b0;
                end
                if (!bus.spi_ss) begin
                    state_nxt = ST_RECV;
                end
            end

            ST_RECV: begin
                // The CRC byte is accepted even if slave select rises with it.
                if (last_rx) begin
                    crc_ok_nxt    = crc_match;
                    reg_addr_nxt  = rx_buf[1];
                    reg_wdata_nxt = rx_buf[5:2];
                    reg_wr_en_nxt = crc_match && (rx_buf[0] == CMD_WR);
                    frame_ok_nxt  = crc_match && (rx_buf[0] == CMD_WR);
                    reg_rd_en_nxt = crc_match && (rx_buf[0] == CMD_RD);
                    state_nxt     = ST_EXEC;
                end else if (bus.spi_ss) begin
                    abort_inc     = 1'b1;
                    status_nxt[3] = 1'b1;
                    state_nxt     = ST_IDLE;
                end else if (bus.rx_strobe) begin
                    rx_buf_nxt[rx_idx] = bus.rx_byte;
                    rx_idx_nxt         = rx_idx + IDX_W'(1);
                end
            end

            ST_EXEC: begin
                state_nxt = ST_DISCARD;
                if (!crc_ok) begin
                    crc_err_inc       = 1'b1;
                    status_nxt[3:0]   = 4'b0000;
                end else if (rx_buf[0] == CMD_WR) begin
                    status_nxt        = {status[7:4] + 4'd1, 4'b0011};
                    last_addr_nxt     = reg_addr;
                end else if (rx_buf[0] == CMD_RD) begin
                    status_nxt[3:0]   = 4'b0011;
                    to_cnt_nxt        = TO_LOAD;
                    state_nxt         = ST_RDWAIT;
                end else begin
                    status_nxt[3:0]   = 4'b0001;
                end
            end

            ST_RDWAIT: begin
                if (bus.reg_rd_valid) begin
                    pend_shadow_nxt = WIRE_W'(bus.reg_rdata);
                    pend_valid_nxt  = 1'b1;
                    status_nxt[7:4] = status[7:4] + 4'd1;
                    status_nxt[2]   = 1'b1;
                    last_addr_nxt   = reg_addr;
                    frame_ok_nxt    = 1'b1;
                    state_nxt       = ST_DISCARD;
                end else if (to_cnt <= TO_W'(1)) begin
                    status_nxt[2]   = 1'b0;
                    status_nxt[3]   = 1'b1;
                    abort_inc       = 1'b1;
                    state_nxt       = ST_DISCARD;
                end else begin
                    to_cnt_nxt      = to_cnt - TO_W'(1);
                end
            end

            ST_DISCARD: begin
                // Overlong frame: count it once, otherwise ignore the extra bytes.
                if (bus.spi_ss) begin
                    state_nxt = ST_IDLE;
                end else if (bus.rx_strobe && !ovl_seen) begin
                    abort_inc    = 1'b1;
                    ovl_seen_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (crc_err_inc && (crc_err_cnt != 8'hFF)) begin
            crc_err_cnt_nxt = crc_err_cnt + 8'd1;
        end
        if (abort_inc && (abort_cnt != 8'hFF)) begin
            abort_cnt_nxt = abort_cnt + 8'd1;
        end

        // Tx index saturates at 7, where the mux returns padding zeros.
        if (bus.spi_ss) begin
            tx_idx_nxt = '0;
        end else if (bus.tx_strobe && (tx_idx != IDX_W'(7))) begin
            tx_idx_nxt = tx_idx + IDX_W'(1);
        end

        case (tx_idx_nxt)
            3'd0:    tx_mux = status;
            3'd1:    tx_mux = last_addr;
            3'd2:    tx_mux = tx_shadow[7:0];
            3'd3:    tx_mux = tx_shadow[15:8];
            3'd4:    tx_mux = tx_shadow[23:16];
            3'd5:    tx_mux = tx_shadow[31:24];
            default: tx_mux = 8'h00;
        endcase
        if (bus.spi_ss || bus.tx_strobe) begin
            tx_byte_nxt = tx_mux;
        end
    end

    assign bus.tx_byte     = tx_byte;
    assign bus.reg_wr_en   = reg_wr_en;
    assign bus.reg_rd_en   = reg_rd_en;
    assign bus.reg_addr    = reg_addr;
    assign bus.reg_wdata   = DATA_WIDTH'(reg_wdata);
    assign bus.frame_ok    = frame_ok;
    assign bus.crc_err_cnt = crc_err_cnt;
    assign bus.abort_cnt   = abort_cnt;

endmodule

// File: tb/tb_hwag_spi_cmd_ctrl.sv
// Directed bench for hwag_spi_cmd_ctrl: drives SPI byte strobes and a register-file
// read responder, and checks register transactions, counters and the readback frame.
module tb_hwag_spi_cmd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hwag_spi_cmd_ctrl_if #(.DATA_WIDTH(32)) bus ();

    hwag_spi_cmd_ctrl #(.DATA_WIDTH(32), .RD_TIMEOUT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;
    int ok_pulses = 0;

    logic [7:0]  fb [0:8];
    logic [7:0]  tx_seen [0:8];
    logic        ex_wr, ex_rd, ex_ok;
    logic [7:0]  ex_addr;
    logic [31:0] ex_wdata;
    int          rd_delay;
    logic [31:0] rd_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int k = 0; k < 8; k++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fb(input logic [7:0] b0, b1, b2, b3, b4, b5);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3; fb[4] = b4; fb[5] = b5;
        fb[7] = 8'h55; fb[8] = 8'h66;
    endtask

    // Lowers slave select and sends n bytes; returns in the cycle after the last strobe.
    task automatic send_bytes(input int n, input bit bad_crc, input bit ss_with_last);
        logic [7:0] crc;
        crc = 8'h00;
        for (int i = 0; i < 6; i++) crc = crc8_upd(crc, fb[i]);
        fb[6] = bad_crc ? (crc ^ 8'h5A) : crc;
        crc = 8'h00;
        bus.spi_ss = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < n; i++) begin
            tx_seen[i]    = bus.tx_byte;
            bus.rx_byte   = fb[i];
            bus.crc_rx    = crc;
            bus.rx_strobe = 1'b1;
            bus.tx_strobe = 1'b1;
            if (i == 6 && ss_with_last) bus.spi_ss = 1'b1;
            tick();
            bus.rx_strobe = 1'b0;
            bus.tx_strobe = 1'b0;
            crc = crc8_upd(crc, fb[i]);
            if (i == 6) begin
                ex_wr    = bus.reg_wr_en;
                ex_rd    = bus.reg_rd_en;
                ex_ok    = bus.frame_ok;
                ex_addr  = bus.reg_addr;
                ex_wdata = bus.reg_wdata;
            end
            if (i != n - 1) repeat (2) tick();
        end
    endtask

    task automatic end_frame();
        tick();
        bus.spi_ss = 1'b1;
        repeat (4) tick();
    endtask

    always @(negedge clk) begin
        if (bus.reg_wr_en) wr_pulses++;
        if (bus.reg_rd_en) rd_pulses++;
        if (bus.frame_ok)  ok_pulses++;
    end

    // Register-file read responder: rd_delay cycles after reg_rd_en, 0 = never answers.
    initial begin
        bus.reg_rd_valid = 1'b0;
        bus.reg_rdata    = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.reg_rd_en && rd_delay > 0) begin
                repeat (rd_delay) @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b1;
                bus.reg_rdata    = rd_data;
                @(posedge clk);
                #1;
                bus.reg_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0, r0, o0, n;
        logic [7:0] a0;
        rd_delay      = 0;
        rd_data       = 32'h0;
        rst           = 1'b1;
        bus.spi_ss    = 1'b1;
        bus.rx_strobe = 1'b0;
        bus.tx_strobe = 1'b0;
        bus.rx_byte   = 8'h00;
        bus.crc_rx    = 8'h00;
        for (int i = 0; i < 9; i++) tx_seen[i] = 8'h00;
        repeat (3) tick();

        check_eq("rst_tx_byte",  32'(bus.tx_byte), 32'h0);
        check_eq("rst_wr_en",    32'(bus.reg_wr_en), 32'h0);
        check_eq("rst_rd_en",    32'(bus.reg_rd_en), 32'h0);
        check_eq("rst_addr",     32'(bus.reg_addr), 32'h0);
        check_eq("rst_wdata",    bus.reg_wdata, 32'h0);
        check_eq("rst_frame_ok", 32'(bus.frame_ok), 32'h0);
        check_eq("rst_crc_err",  32'(bus.crc_err_cnt), 32'h0);
        check_eq("rst_abort",    32'(bus.abort_cnt), 32'h0);
        rst = 1'b0;
        repeat (2) tick();

        // Valid write
        w0 = wr_pulses;
        set_fb(8'h01, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12);
        send_bytes(7, 1'b0, 1'b0);
        check_eq("wr_en_at_exec", 32'(ex_wr), 32'h1);
        check_eq("wr_frame_ok",   32'(ex_ok), 32'h1);
        check_eq("wr_addr",       32'(ex_addr), 32'h10);
        check_eq("wr_wdata",      ex_wdata, 32'h12345678);
        tick();
        check_eq("wr_en_one_cycle", 32'(bus.reg_wr_en), 32'h0);
        end_frame();
        check_eq("wr_pulse_count", 32'(wr_pulses - w0), 32'h1);

        // Read with 3-cycle latency; status/addr of the write come back first
        rd_delay = 3;
        rd_data  = 32'hDEADBEEF;
        o0 = ok_pulses;
        set_fb(8'h02, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00);
        send_bytes(7, 1'b0, 1'b0);
        check_eq("wr_status_tx0", 32'(tx_seen[0]), 32'h13);
        check_eq("wr_addr_tx1",   32'(tx_seen[1]), 32'h10);
        check_eq("rd_en_at_exec", 32'(ex_rd), 32'h1);
        check_eq("rd_no_wr",      32'(ex_wr), 32'h0);
        n = 0;
        while (!bus.frame_ok && n < 20) begin
            tick();
            n++;
        end
        check_eq("rd_frame_ok_latency", 32'(n), 32'd4);
        end_frame();
        check_eq("rd_frame_ok_count", 32'(ok_pulses - o0), 32'h1);
        check_eq("rd_status", 32'(bus.tx_byte), 32'h27);

        // Unknown command; also reads back the committed read data
        w0 = wr_pulses; r0 = rd_pulses; o0 = ok_pulses;
        set_fb(8'h7F, 8'h21, 8'h01, 8'h02, 8'h03, 8'h04);
        send_bytes(7, 1'b0, 1'b0);
        check_eq("rd_tx1_addr", 32'(tx_seen[1]), 32'h20);
        check_eq("rd_tx2", 32'(tx_seen[2]), 32'hEF);
        check_eq("rd_tx3", 32'(tx_seen[3]), 32'hBE);
        check_eq("rd_tx4", 32'(tx_seen[4]), 32'hAD);
        check_eq("rd_tx5", 32'(tx_seen[5]), 32'hDE);
        end_frame();
        check_eq("unk_no_access", 32'((wr_pulses - w0) + (rd_pulses - r0) + (ok_pulses - o0)), 32'h0);
        check_eq("unk_status_bit1", 32'(bus.tx_byte & 8'h02), 32'h0);
        check_eq("unk_status_bit0", 32'(bus.tx_byte & 8'h01), 32'h1);

        // Bad CRC
        w0 = wr_pulses;
        set_fb(8'h01, 8'h30, 8'h11, 8'h22, 8'h33, 8'h44);
        send_bytes(7, 1'b1, 1'b0);
        end_frame();
        check_eq("bad_crc_no_wr",  32'(wr_pulses - w0), 32'h0);
        check_eq("bad_crc_count",  32'(bus.crc_err_cnt), 32'h1);
        check_eq("bad_crc_status_bit0", 32'(bus.tx_byte & 8'h01), 32'h0);

        // Short frame (4 bytes)
        w0 = wr_pulses;
        set_fb(8'h01, 8'h31, 8'h11, 8'h22, 8'h33, 8'h44);
        send_bytes(4, 1'b0, 1'b0);
        end_frame();
        check_eq("short_no_wr", 32'(wr_pulses - w0), 32'h0);
        check_eq("short_abort", 32'(bus.abort_cnt), 32'h1);
        check_eq("short_status_bit3", 32'(bus.tx_byte & 8'h08), 32'h8);

        // Overlong 9-byte write
        w0 = wr_pulses;
        set_fb(8'h01, 8'h40, 8'hAA, 8'hBB, 8'hCC, 8'hDD);
        send_bytes(9, 1'b0, 1'b0);
        end_frame();
        check_eq("long_wr_en",  32'(ex_wr), 32'h1);
        check_eq("long_wdata",  ex_wdata, 32'hDDCCBBAA);
        check_eq("long_wr_count", 32'(wr_pulses - w0), 32'h1);
        check_eq("long_abort",  32'(bus.abort_cnt), 32'h2);

        // Read timeout: 15 wait cycles after reg_rd_en, counter visible one cycle later
        rd_delay = 0;
        o0 = ok_pulses;
        a0 = bus.abort_cnt;
        set_fb(8'h02, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00);
        send_bytes(7, 1'b0, 1'b0);
        check_eq("to_rd_en", 32'(ex_rd), 32'h1);
        n = 0;
        while (bus.abort_cnt == a0 && n < 40) begin
            tick();
            n++;
        end
        check_eq("to_latency", 32'(n), 32'd16);
        end_frame();
        check_eq("to_abort", 32'(bus.abort_cnt), 32'h3);
        check_eq("to_no_frame_ok", 32'(ok_pulses - o0), 32'h0);
        check_eq("to_status_bit2", 32'(bus.tx_byte & 8'h04), 32'h0);
        check_eq("to_status_bit3", 32'(bus.tx_byte & 8'h08), 32'h8);

        set_fb(8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        send_bytes(7, 1'b0, 1'b0);
        end_frame();
        check_eq("to_tx1_last_addr", 32'(tx_seen[1]), 32'h40);
        check_eq("to_shadow_kept", {tx_seen[5], tx_seen[4], tx_seen[3], tx_seen[2]}, 32'hDEADBEEF);

        // Slave select rises together with the CRC byte
        w0 = wr_pulses;
        set_fb(8'h01, 8'h60, 8'h01, 8'h02, 8'h03, 8'h04);
        send_bytes(7, 1'b0, 1'b1);
        check_eq("ss_edge_wr_en", 32'(ex_wr), 32'h1);
        check_eq("ss_edge_addr",  32'(ex_addr), 32'h60);
        check_eq("ss_edge_wdata", ex_wdata, 32'h04030201);
        end_frame();
        check_eq("ss_edge_wr_count", 32'(wr_pulses - w0), 32'h1);

        // Reset asserted during EXEC
        set_fb(8'h01, 8'h70, 8'h09, 8'h08, 8'h07, 8'h06);
        send_bytes(7, 1'b0, 1'b0);
        check_eq("rst_exec_wr_en", 32'(ex_wr), 32'h1);
        rst = 1'b1;
        bus.spi_ss = 1'b1;
        tick();
        check_eq("rst_exec_wr_en_after", 32'(bus.reg_wr_en), 32'h0);
        check_eq("rst_exec_frame_ok",    32'(bus.frame_ok), 32'h0);
        check_eq("rst_exec_addr",        32'(bus.reg_addr), 32'h0);
        check_eq("rst_exec_wdata",       bus.reg_wdata, 32'h0);
        check_eq("rst_exec_tx_byte",     32'(bus.tx_byte), 32'h0);
        check_eq("rst_exec_counters",    32'({bus.crc_err_cnt, bus.abort_cnt}), 32'h0);
        rst = 1'b0;
        w0 = wr_pulses;
        repeat (5) tick();
        check_eq("rst_exec_no_late_wr", 32'(wr_pulses - w0), 32'h0);

        // Abort counter saturates at 255
        set_fb(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        repeat (260) begin
            send_bytes(1, 1'b0, 1'b0);
            end_frame();
        end
        check_eq("abort_saturate", 32'(bus.abort_cnt), 32'd255);
        check_eq("crc_err_untouched", 32'(bus.crc_err_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
